uart_tx_cfg: RTL and testbench

- Parametrised UART transmitter that serialises one word per frame onto `tx`.
- Frame format is configurable at elaboration: data width, parity mode and stop-bit count.
- Uses a ready/valid input handshake and supports zero-gap back-to-back frames.
- Sits between the byte-producing logic (FIFO or command engine) and the board TX pin; successor of the fixed 8N1 transmitter.

---
 rtl/uart_tx_cfg.sv | 96 +++++++++
 tb/tb_uart_tx_cfg.sv | 133 +++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable-format UART transmitter with ready/valid input and zero-gap back-to-back frames
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 2000000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_data_valid,
  output logic                 tx_data_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal parameter combination");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [3:0] bit_cnt, bit_n;
  logic stop_cnt, stop_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic par_bit, par_n, tx_n;
  logic bw, last_data, last_stop, accept;
  assign bw = baud_cnt == DIV_M1;
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
  assign tx_done = state == STOP && last_stop && bw;
  // gated by rst so the block never advertises readiness while held in reset
  assign tx_data_ready = !rst && (state == IDLE || tx_done);
  assign accept = tx_data_valid && tx_data_ready;
  assign tx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    bit_n = bit_cnt;
    stop_n = stop_cnt;
    par_n = par_bit;
    baud_n = (state == IDLE || bw) ? '0 : baud_cnt + 16'd1;
    case (state)
      IDLE: ;
      START: if (bw) state_n = DATA;
      DATA: if (bw) begin
        shift_n = shift_reg >> 1;
        bit_n = last_data ? '0 : bit_cnt + 4'd1;
        if (last_data) begin
          state_n = (PARITY != 0) ? PAR : STOP;
          stop_n = '0;
        end
      end
      PAR: if (bw) begin
        state_n = STOP;
        stop_n = '0;
      end
      STOP: if (bw) begin
        stop_n = stop_cnt + 1'b1;
        if (last_stop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      state_n = START;
      shift_n = tx_data_i;
      bit_n = '0;
      stop_n = '0;
      par_n = (^tx_data_i) ^ (PARITY == 2);
      baud_n = '0;
    end
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : (state_n == PAR) ? par_n : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= '0;
      shift_reg <= '0;
      par_bit <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_cnt <= bit_n;
      stop_cnt <= stop_n;
      shift_reg <= shift_n;
      par_bit <= par_n;
      tx <= tx_n;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed checks of frame format, parity modes, back-to-back and reset abort
module tb_uart_tx_cfg;
  logic clk = 0, rst = 1;
  logic [7:0] d = '0;
  logic [3:0] valid = '0, ready, tx_v, busy, done;
  int checks = 0, errors = 0;
  logic cap_tx [0:127], cap_busy [0:127], cap_done [0:127];
  int ndone, dpos, dpos2, nbusy;
  always #5 clk = ~clk;
  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7E2, all DIV = 4
  uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(25000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data_i(d), .tx_data_valid(valid[0]), .tx_data_ready(ready[0]),
    .tx(tx_v[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(25000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_data_i(d), .tx_data_valid(valid[1]), .tx_data_ready(ready[1]),
    .tx(tx_v[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(25000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_data_i(d), .tx_data_valid(valid[2]), .tx_data_ready(ready[2]),
    .tx(tx_v[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(25000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_data_i(d[6:0]), .tx_data_valid(valid[3]), .tx_data_ready(ready[3]),
    .tx(tx_v[3]), .tx_busy(busy[3]), .tx_done(done[3]));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  // sample n clocks starting the clock after the accepting edge; d switches to d1 then
  task automatic frame(input int k, input logic [7:0] d0, input logic [7:0] d1, input int hold, input int n);
    chk("ready_before_send", 32'(ready[k]), 1);
    @(negedge clk);
    d = d0;
    valid[k] = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0; dpos = -1; dpos2 = -1; nbusy = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == 0) d = d1;
      if (i == hold) valid[k] = 1'b0;
      cap_tx[i] = tx_v[k];
      cap_busy[i] = busy[k];
      cap_done[i] = done[k];
      if (busy[k]) nbusy++;
      if (done[k]) begin
        ndone++;
        if (dpos < 0) dpos = i; else dpos2 = i;
      end
    end
  endtask
  function automatic logic [15:0] cbits(input int off, input int nb);
    logic [15:0] r = '0;
    for (int b = 0; b < nb; b++) r[b] = cap_tx[off + 4*b + 1];
    return r;
  endfunction
  function automatic int unstable(input int off, input int nb);
    int c = 0;
    for (int b = 0; b < nb; b++)
      for (int j = 1; j < 4; j++) if (cap_tx[off + 4*b + j] !== cap_tx[off + 4*b]) c++;
    return c;
  endfunction
  initial begin
    #12;
    chk("rst_tx", 32'(tx_v[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_ready", 32'(ready[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(ready[0]), 1);
    chk("idle_tx", 32'(tx_v[0]), 1);
    chk("idle_busy", 32'(busy[0]), 0);
    chk("idle_done", 32'(done[0]), 0);
    frame(0, 8'hA5, 8'hA5, 0, 41);
    chk("a5_bits", 32'(cbits(0, 10)), 32'b1101001010);
    chk("a5_stable", unstable(0, 10), 0);
    chk("a5_ndone", ndone, 1);
    chk("a5_dpos", dpos, 39);
    chk("a5_nbusy", nbusy, 40);
    chk("a5_busy_end", 32'(cap_busy[40]), 0);
    chk("a5_tx_end", 32'(cap_tx[40]), 1);
    frame(1, 8'h07, 8'h07, 0, 45);
    chk("even_bits", 32'(cbits(0, 11)), 32'b11000001110);
    chk("even_dpos", dpos, 43);
    frame(2, 8'h07, 8'h07, 0, 45);
    chk("odd_bits", 32'(cbits(0, 11)), 32'b10000001110);
    chk("odd_stable", unstable(0, 11), 0);
    frame(3, 8'h55, 8'h55, 0, 45);
    chk("7e2_bits", 32'(cbits(0, 11)), 32'b11010101010);
    chk("7e2_nbusy", nbusy, 44);
    chk("7e2_dpos", dpos, 43);
    chk("7e2_ndone", ndone, 1);
    frame(0, 8'h01, 8'h80, 40, 81);
    chk("b2b_f1", 32'(cbits(0, 10)), 32'b1000000010);
    chk("b2b_f2", 32'(cbits(40, 10)), 32'b1100000000);
    chk("b2b_stable", unstable(0, 20), 0);
    chk("b2b_ndone", ndone, 2);
    chk("b2b_dpos", dpos, 39);
    chk("b2b_gap", dpos2 - dpos, 40);
    chk("b2b_nbusy", nbusy, 80);
    chk("b2b_start2", 32'({cap_tx[39], cap_tx[40]}), 32'b10);
    frame(0, 8'h00, 8'hFF, 0, 41);
    chk("stab_bits", 32'(cbits(0, 10)), 32'b1000000000);
    chk("stab_ndone", ndone, 1);
    frame(0, 8'h00, 8'h00, 0, 18);
    chk("mid_tx_low", 32'(tx_v[0]), 0);
    chk("mid_busy", 32'(busy[0]), 1);
    #2 rst = 1;
    #1;
    chk("abort_tx", 32'(tx_v[0]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_done", 32'(done[0]), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("post_ready", 32'(ready[0]), 1);
    frame(0, 8'h3C, 8'h3C, 0, 41);
    chk("3c_bits", 32'(cbits(0, 10)), 32'b1001111000);
    chk("3c_stable", unstable(0, 10), 0);
    chk("3c_dpos", dpos, 39);
    chk("3c_ndone", ndone, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
